// File: rtl/fetch_unit_pkg.sv
// Shared CPU fetch definitions: fetch FSM state encoding, default NOP word and word-align mask.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hffff_fffc;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding non-abortable bus read feeding a single registered decode slot.
// Optional misaligned-PC address-error trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        pc_enable,
    input  logic        flush,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        exc_adel
);

    fetch_state_e state;
    logic         slot_free;
    logic         slot_taken;

    assign slot_free  = !inst_valid || id_ready;
    assign slot_taken = inst_valid && id_ready;
    assign pc_enable  = (state == ST_WAIT) && ibus_ack && !flush;

`ifdef FETCH_ALIGN_CHECK_EN
    // Set once the trap entry is posted so it is not re-posted after decode consumes it.
    logic adel_hold;
    logic misaligned;
    assign misaligned = pc[1:0] != 2'b00;
`else
    assign exc_adel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ibus_req   <= 1'b0;
            ibus_addr  <= '0;
            inst_valid <= 1'b0;
            inst       <= NOP_WORD;
            inst_pc    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            exc_adel   <= 1'b0;
            adel_hold  <= 1'b0;
`endif
        end else begin
            // Slot drains on consume or flush; a load below in the same cycle wins.
            if (flush || slot_taken) begin
                inst_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                exc_adel   <= 1'b0;
`endif
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (flush) begin
                adel_hold <= 1'b0;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (!flush && slot_free) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned || adel_hold) begin
                            if (!adel_hold) begin
                                inst       <= NOP_WORD;
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                                exc_adel   <= 1'b1;
                                adel_hold  <= 1'b1;
                            end
                        end else begin
                            ibus_req  <= 1'b1;
                            ibus_addr <= pc & WORD_ALIGN_MASK;
                            state     <= ST_WAIT;
                        end
`else
                        ibus_req  <= 1'b1;
                        ibus_addr <= pc & WORD_ALIGN_MASK;
                        state     <= ST_WAIT;
`endif
                    end
                end
                ST_WAIT: begin
                    if (ibus_ack) begin
                        ibus_req <= 1'b0;
                        state    <= ST_IDLE;
                        if (!flush) begin
                            inst       <= ibus_rdata;
                            inst_pc    <= ibus_addr;
                            inst_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (ibus_ack) begin
                        ibus_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    ibus_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
